// File: rtl/alu_issue_queue.sv
// ALU issue queue: DEPTH-entry operand FIFO feeding an external combinational ALU,
// with a one-entry result holding stage. Optional `level` port under ALU_ISSUE_QUEUE_LEVEL_EN.
module alu_issue_queue #(
    parameter int DEPTH = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       in_valid,
    output logic       in_ready,
    input  logic [5:0] in_a,
    input  logic [5:0] in_b,
    input  logic [2:0] in_fxn,
    output logic [5:0] alu_a,
    output logic [5:0] alu_b,
    output logic [2:0] alu_fxn,
    input  logic [5:0] alu_ans,
    output logic       res_valid,
    input  logic       res_ready,
    output logic [5:0] res_data,
    output logic [2:0] res_fxn
`ifdef ALU_ISSUE_QUEUE_LEVEL_EN
    ,
    output logic [$clog2(DEPTH):0] level
`endif
);

    // state | meaning
    // IDLE  | no result held, res_valid=0
    // HOLD  | res_data/res_fxn hold a result, res_valid=1
    typedef enum logic {IDLE = 1'b0, HOLD = 1'b1} state_t;

    localparam int PW = $clog2(DEPTH);
    localparam logic [PW:0] FULL = DEPTH[PW:0];

    logic [14:0]   mem [DEPTH];
    logic [PW-1:0] wptr, rptr;
    logic [PW:0]   count;
    state_t        state_q, state_d;
    logic          push, pop;

    assign in_ready  = (count < FULL) && !rst;
    assign push      = in_valid && in_ready;
    assign alu_a     = mem[rptr][14:9];
    assign alu_b     = mem[rptr][8:3];
    assign alu_fxn   = mem[rptr][2:0];
    assign res_valid = (state_q == HOLD);

`ifdef ALU_ISSUE_QUEUE_LEVEL_EN
    assign level = count;
`endif

    always_comb begin
        state_d = state_q;
        pop     = 1'b0;
        case (state_q)
            IDLE: begin
                if (count != '0) begin
                    pop     = 1'b1;
                    state_d = HOLD;
                end
            end
            HOLD: begin
                if (res_ready) begin
                    if (count != '0) pop = 1'b1;
                    else             state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            wptr     <= '0;
            rptr     <= '0;
            count    <= '0;
            res_data <= '0;
            res_fxn  <= '0;
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else begin
            state_q <= state_d;
            if (push) begin
                mem[wptr] <= {in_a, in_b, in_fxn};
                wptr      <= wptr + 1'b1;
            end
            // The ALU result is taken from the head entry in the same cycle it is popped.
            if (pop) begin
                res_data <= alu_ans;
                res_fxn  <= alu_fxn;
                rptr     <= rptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_issue_queue.sv
// Scoreboard bench for alu_issue_queue: accepted ops queue their expected result,
// a negedge monitor tracks occupancy/hold at transaction level and checks every output.
module tb_alu_issue_queue;

    localparam int DEPTH = 4;

    logic       clk, rst;
    logic       in_valid, in_ready;
    logic [5:0] in_a, in_b;
    logic [2:0] in_fxn;
    logic [5:0] alu_a, alu_b, alu_ans;
    logic [2:0] alu_fxn;
    logic       res_valid, res_ready;
    logic [5:0] res_data;
    logic [2:0] res_fxn;
`ifdef ALU_ISSUE_QUEUE_LEVEL_EN
    logic [$clog2(DEPTH):0] level;
`endif

    alu_issue_queue #(.DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_a(in_a), .in_b(in_b), .in_fxn(in_fxn),
        .alu_a(alu_a), .alu_b(alu_b), .alu_fxn(alu_fxn), .alu_ans(alu_ans),
        .res_valid(res_valid), .res_ready(res_ready),
        .res_data(res_data), .res_fxn(res_fxn)
`ifdef ALU_ISSUE_QUEUE_LEVEL_EN
        , .level(level)
`endif
    );

    function automatic logic [5:0] alu_ref(input logic [5:0] a, input logic [5:0] b,
                                           input logic [2:0] f);
        logic [5:0] r;
        case (f)
            3'd0: r = a + b;
            3'd1: r = a - b;
            3'd2: r = a & b;
            3'd3: r = a | b;
            3'd4: r = a ^ b;
            3'd5: r = ~(a ^ b);
            3'd6: r = {a[4:0], 1'b0};
            default: r = b;
        endcase
        return r;
    endfunction

    assign alu_ans = alu_ref(alu_a, alu_b, alu_fxn);

    typedef struct packed {
        logic [5:0] data;
        logic [2:0] fxn;
    } exp_t;

    exp_t exp_q[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    task automatic check(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Stimulus side: every accepted op queues its expected result.
    always @(negedge clk) begin
        if (!rst && in_valid && in_ready)
            exp_q.push_back('{data: alu_ref(in_a, in_b, in_fxn), fxn: in_fxn});
    end

    // Monitor: transaction-level occupancy model plus result scoreboard.
    int mcnt  = 0;
    bit mhold = 0;
    initial begin
        bit   pushm, capm, consm;
        exp_t e;
        forever begin
            @(negedge clk);
            #1;
            check("in_ready", int'(in_ready), int'((mcnt < DEPTH) && !rst));
            check("res_valid", int'(res_valid), int'(mhold));
`ifdef ALU_ISSUE_QUEUE_LEVEL_EN
            check("level", int'(level), mcnt);
`endif
            pushm = in_valid && !rst && (mcnt < DEPTH);
            capm  = (mcnt > 0) && (!mhold || res_ready);
            consm = mhold && res_ready;
            if (consm && res_valid && !rst) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_result", 1, 0);
                end else begin
                    e = exp_q.pop_front();
                    check("res_data", int'(res_data), int'(e.data));
                    check("res_fxn", int'(res_fxn), int'(e.fxn));
                end
            end
            if (rst) begin
                mcnt  = 0;
                mhold = 0;
                exp_q.delete();
            end else begin
                mcnt  = mcnt + int'(pushm) - int'(capm);
                mhold = capm ? 1'b1 : (consm ? 1'b0 : mhold);
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic offer(input logic [5:0] a, input logic [5:0] b, input logic [2:0] f,
                         input int max_wait, output bit ok);
        bit acc;
        ok       = 0;
        in_valid = 1'b1;
        in_a     = a;
        in_b     = b;
        in_fxn   = f;
        for (int t = 0; t < max_wait; t++) begin
            @(negedge clk);
            acc = in_ready;
            step();
            if (acc) begin
                ok = 1;
                break;
            end
        end
        in_valid = 1'b0;
    endtask

    initial begin
        bit ok;
        rst = 1'b1; in_valid = 1'b0; in_a = '0; in_b = '0; in_fxn = '0; res_ready = 1'b0;
        repeat (3) step();
        rst = 1'b0;
        check("reset_alu_a", int'(alu_a), 0);
        check("reset_alu_b", int'(alu_b), 0);
        check("reset_alu_fxn", int'(alu_fxn), 0);
        check("reset_res_data", int'(res_data), 0);

        // Single xnor op: 0F xnor 33 = 03, visible one cycle after accept.
        res_ready = 1'b1;
        offer(6'h0F, 6'h33, 3'd5, 4, ok);
        check("single_accept", int'(ok), 1);
        step();
        check("single_res_valid", int'(res_valid), 1);
        check("single_res_data", int'(res_data), 6'h03);
        check("single_res_fxn", int'(res_fxn), 5);
        repeat (2) step();

        // Back-to-back pass-through ops.
        for (int i = 1; i <= 6; i++) begin
            in_valid = 1'b1; in_a = 6'(i); in_b = '0; in_fxn = 3'd0;
            @(negedge clk);
            check("b2b_in_ready", int'(in_ready), 1);
            step();
        end
        in_valid = 1'b0;
        repeat (4) step();

        // Fill: one op sits in HOLD, DEPTH more fill the queue.
        res_ready = 1'b0;
        for (int i = 0; i <= DEPTH; i++) begin
            offer(6'(10 + i), 6'(3 * i), 3'(i), 4, ok);
            check("fill_accept", int'(ok), 1);
        end
        in_valid = 1'b1; in_a = 6'h2A; in_b = 6'h15; in_fxn = 3'd4;
        repeat (3) begin
            @(negedge clk);
            check("full_blocked", int'(in_ready), 0);
            step();
        end
        // Simultaneous pop and offer at full: in_ready stays low this cycle.
        res_ready = 1'b1;
        @(negedge clk);
        check("full_pop_in_ready", int'(in_ready), 0);
        step();
        res_ready = 1'b0;
        offer(6'h2A, 6'h15, 3'd4, 3, ok);
        check("full_late_accept", int'(ok), 1);
        res_ready = 1'b1;
        repeat (DEPTH + 4) step();

        // Reset with work outstanding.
        res_ready = 1'b0;
        for (int i = 0; i < 3; i++) offer(6'(20 + i), 6'(7 + i), 3'(i + 1), 4, ok);
        step();
        check("pre_reset_res_valid", int'(res_valid), 1);
        rst = 1'b1;
        step();
        rst = 1'b0;
        check("post_reset_res_valid", int'(res_valid), 0);
        check("post_reset_alu_a", int'(alu_a), 0);
        check("post_reset_res_data", int'(res_data), 0);
        res_ready = 1'b1;
        repeat (4) step();

        // Random traffic.
        for (int c = 0; c < 400; c++) begin
            in_valid  = 1'($urandom_range(0, 1));
            in_a      = 6'($urandom);
            in_b      = 6'($urandom);
            in_fxn    = 3'($urandom);
            res_ready = ($urandom_range(0, 3) != 0);
            if (c % 97 == 50) rst = 1'b1;
            step();
            rst = 1'b0;
        end

        in_valid  = 1'b0;
        res_ready = 1'b1;
        repeat (DEPTH + 4) step();
        check("drain_empty", exp_q.size(), 0);
        check("drain_res_valid", int'(res_valid), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
